fpu_op_scheduler: RTL and testbench

Command sequencer in front of the FPU datapath (fclass … sqrt units). It buffers FPU commands in a small in-order FIFO and issues them one at a time. It drives the one-hot unit valid and operands, handles the multi-cycle divider and sqrt with a completion wait and timeout, and returns one result per command. It sits between the register/bus interface and the unit instances, replacing direct valid_in pokes.

---
 rtl/fpu_sched_pkg.sv | 40 ++++
 rtl/fpu_cmd_fifo.sv | 59 +++++
 rtl/fpu_op_scheduler.sv | 176 +++++++++++++++++
 tb/tb_fpu_op_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU command scheduler and its command FIFO.
package fpu_sched_pkg;

  localparam int NUM_UNITS = 11;

  localparam logic [3:0] OP_FCLASS = 4'd0;
  localparam logic [3:0] OP_SINJ   = 4'd1;
  localparam logic [3:0] OP_CMP    = 4'd2;
  localparam logic [3:0] OP_MINMAX = 4'd3;
  localparam logic [3:0] OP_I2F    = 4'd4;
  localparam logic [3:0] OP_F2I    = 4'd5;
  localparam logic [3:0] OP_ADDSUB = 4'd6;
  localparam logic [3:0] OP_MUL    = 4'd7;
  localparam logic [3:0] OP_FMA    = 4'd8;
  localparam logic [3:0] OP_DIV    = 4'd9;
  localparam logic [3:0] OP_SQRT   = 4'd10;

  localparam int EXC_NV = 4;
  localparam int EXC_DZ = 3;
  localparam int EXC_OF = 2;
  localparam int EXC_UF = 1;
  localparam int EXC_NX = 0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MC, DONE} sched_state_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [1:0]  op;
    logic [2:0]  frm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } cmd_t;

  // sign-inject and compare have only three sub-operations; op 3 is reserved
  function automatic logic is_illegal(input logic [3:0] sel, input logic [1:0] op);
    return (sel > OP_SQRT) || (((sel == OP_SINJ) || (sel == OP_CMP)) && (op == 2'b11));
  endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// In-order command buffer for the FPU scheduler; head entry is presented
// combinationally and flush empties it on the next edge.
module fpu_cmd_fifo
  import fpu_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  cmd_t                   push_data,
  output cmd_t                   head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage carries no reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_op_scheduler.sv
// Issues buffered FPU commands one at a time, waits on div/sqrt completion
// with a timeout, and returns exactly one result per command in order.
module fpu_op_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_sel,
  input  logic [1:0]             cmd_op,
  input  logic [2:0]             cmd_frm,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  input  logic [31:0]            cmd_c,
  input  logic                   flush,
  output logic [NUM_UNITS-1:0]   fpu_valid_in,
  output logic [1:0]             fpu_op,
  output logic [2:0]             fpu_frm,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  output logic [31:0]            fpu_c,
  output logic                   fpu_cancel,
  input  logic [31:0]            fpu_result,
  input  logic [4:0]             fpu_exc,
  input  logic                   div_valid_out,
  input  logic                   sqrt_valid_out,
  output logic                   res_valid,
  output logic [31:0]            res_data,
  output logic [4:0]             res_exc,
  output logic                   res_illegal,
  output logic                   res_timeout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  sched_state_t  state, next_state;
  cmd_t          push_cmd, head;
  logic          fifo_empty, fifo_full, pop;
  logic [3:0]    issue_sel;
  logic [TW-1:0] timer;
  logic          timer_clr, mc_done;
  logic          cap_en, cap_ill, cap_to;
  logic [31:0]   cap_data;
  logic [4:0]    cap_exc;

  assign push_cmd  = '{sel: cmd_sel, op: cmd_op, frm: cmd_frm, a: cmd_a, b: cmd_b, c: cmd_c};
  assign cmd_ready = !fifo_full && !flush;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign mc_done   = (issue_sel == OP_DIV) ? div_valid_out : sqrt_valid_out;

  fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .push      (cmd_valid && cmd_ready),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_cmd),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= next_state;
  end

  // flush suppresses the unit pulse too, so an aborted issue never starts a unit
  always_comb begin
    next_state   = state;
    pop          = 1'b0;
    timer_clr    = 1'b0;
    cap_en       = 1'b0;
    cap_ill      = 1'b0;
    cap_to       = 1'b0;
    cap_data     = '0;
    cap_exc      = '0;
    fpu_valid_in = '0;
    fpu_cancel   = 1'b0;
    res_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && !fifo_empty) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (flush) begin
          next_state = IDLE;
        end else if (is_illegal(issue_sel, fpu_op)) begin
          cap_en     = 1'b1;
          cap_ill    = 1'b1;
          next_state = DONE;
        end else begin
          fpu_valid_in = NUM_UNITS'(1) << issue_sel;
          if (issue_sel >= OP_DIV) begin
            timer_clr  = 1'b1;
            next_state = WAIT_MC;
          end else begin
            cap_en     = 1'b1;
            cap_data   = fpu_result;
            cap_exc    = fpu_exc;
            next_state = DONE;
          end
        end
      end
      WAIT_MC: begin
        if (flush) begin
          fpu_cancel = 1'b1;
          next_state = IDLE;
        end else if (mc_done) begin
          cap_en     = 1'b1;
          cap_data   = fpu_result;
          cap_exc    = fpu_exc;
          next_state = DONE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          cap_en     = 1'b1;
          cap_to     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        res_valid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      issue_sel <= '0;
      fpu_op    <= '0;
      fpu_frm   <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_c     <= '0;
    end else if (pop) begin
      issue_sel <= head.sel;
      fpu_op    <= head.op;
      fpu_frm   <= head.frm;
      fpu_a     <= head.a;
      fpu_b     <= head.b;
      fpu_c     <= head.c;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                 timer <= '0;
    else if (timer_clr)         timer <= '0;
    else if (state == WAIT_MC)  timer <= timer + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      res_data    <= '0;
      res_exc     <= '0;
      res_illegal <= 1'b0;
      res_timeout <= 1'b0;
    end else if (cap_en) begin
      res_data    <= cap_data;
      res_exc     <= cap_exc;
      res_illegal <= cap_ill;
      res_timeout <= cap_to;
    end
  end

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Self-checking bench for fpu_op_scheduler: directed steps plus a randomized
// burst, scored against a queue-based model of per-command results.
module tb_fpu_op_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  exc;
    logic        ill;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_sel;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_frm;
  logic [31:0] cmd_a, cmd_b, cmd_c;
  logic        flush;
  logic [10:0] fpu_valid_in;
  logic [1:0]  fpu_op;
  logic [2:0]  fpu_frm;
  logic [31:0] fpu_a, fpu_b, fpu_c;
  logic        fpu_cancel;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_exc;
  logic        div_valid_out, sqrt_valid_out;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_exc;
  logic        res_illegal, res_timeout, busy;
  logic [2:0]  fifo_count;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   vin_cnt [11];
  int   res_seen = 0;
  exp_t exp_q [$];
  int   mc_delay_q [$];
  exp_t mon_e;

  int   mc_sel = 0;
  int   mc_left = 0;
  int   act_sel;
  logic see_cancel, see_div, see_sqrt;
  logic resp_div = 1'b0, resp_sqrt = 1'b0;
  logic stray_div = 1'b0, stray_sqrt = 1'b0;

  assign div_valid_out  = resp_div | stray_div;
  assign sqrt_valid_out = resp_sqrt | stray_sqrt;

  fpu_op_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_l(rst_l), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_op(cmd_op), .cmd_frm(cmd_frm),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .flush(flush),
    .fpu_valid_in(fpu_valid_in), .fpu_op(fpu_op), .fpu_frm(fpu_frm),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_cancel(fpu_cancel),
    .fpu_result(fpu_result), .fpu_exc(fpu_exc),
    .div_valid_out(div_valid_out), .sqrt_valid_out(sqrt_valid_out),
    .res_valid(res_valid), .res_data(res_data), .res_exc(res_exc),
    .res_illegal(res_illegal), .res_timeout(res_timeout),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // stand-in for the FPU units: a few known IEEE results, otherwise a mixing hash
  function automatic logic [36:0] unit_model(input int sel, input logic [1:0] op, input logic [2:0] frm,
                                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] d;
    logic [4:0]  e;
    if (sel == 6 && op == 2'd0 && a == 32'h3F800000 && b == 32'h40000000) return {5'b00000, 32'h40400000};
    if (sel == 9 && b == 32'h0) return {5'b01000, 32'h7F800000};
    d = (a ^ {b[15:0], b[31:16]}) + c + (32'(sel) * 32'h01010101) + {27'd0, op, frm};
    e = a[4:0] ^ b[9:5] ^ 5'(sel) ^ {frm, op};
    return {e, d};
  endfunction

  always_comb begin
    act_sel = mc_sel;
    for (int i = 0; i < 11; i++) if (fpu_valid_in[i]) act_sel = i;
    {fpu_exc, fpu_result} = unit_model(act_sel, fpu_op, fpu_frm, fpu_a, fpu_b, fpu_c);
  end

  // div/sqrt responder: done is raised delay-1 cycles into the wait; delay 0 never answers
  always @(posedge clk) begin
    see_cancel = fpu_cancel;
    see_div    = fpu_valid_in[9];
    see_sqrt   = fpu_valid_in[10];
    #1;
    resp_div  = 1'b0;
    resp_sqrt = 1'b0;
    if (!rst_l || see_cancel) mc_left = 0;
    else if (see_div || see_sqrt) begin
      mc_sel  = see_div ? 9 : 10;
      mc_left = (mc_delay_q.size() > 0) ? mc_delay_q.pop_front() : 0;
    end else if (mc_left > 0) mc_left--;
    if (mc_left == 1) begin
      if (mc_sel == 9) resp_div = 1'b1;
      else             resp_sqrt = 1'b1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst_l) begin
      if (fpu_valid_in != '0) begin
        check_output("vin_onehot", 32'($onehot(fpu_valid_in)), 1);
        for (int i = 0; i < 11; i++) if (fpu_valid_in[i]) vin_cnt[i]++;
      end
      if (res_valid) begin
        res_seen++;
        if (exp_q.size() == 0) check_output("unexpected_res", 32'(res_valid), 0);
        else begin
          mon_e = exp_q.pop_front();
          check_output("res_data", res_data, mon_e.data);
          check_output("res_exc", 32'(res_exc), 32'(mon_e.exc));
          check_output("res_illegal", 32'(res_illegal), 32'(mon_e.ill));
          check_output("res_timeout", 32'(res_timeout), 32'(mon_e.to));
        end
      end
    end
  end

  function automatic int total_vin();
    int s = 0;
    for (int i = 0; i < 11; i++) s += vin_cnt[i];
    return s;
  endfunction

  task automatic apply_stimulus(input int sel, input logic [1:0] op, input logic [2:0] frm,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                input int dly, output logic acc);
    exp_t e;
    @(negedge clk);
    cmd_sel = 4'(sel); cmd_op = op; cmd_frm = frm;
    cmd_a = a; cmd_b = b; cmd_c = c;
    cmd_valid = 1'b1;
    acc = cmd_ready;
    if (acc) begin
      if (sel > 10 || ((sel == 1 || sel == 2) && op == 2'b11)) e = '{32'd0, 5'd0, 1'b1, 1'b0};
      else if (sel >= 9 && (dly == 0 || dly > TIMEOUT))        e = '{32'd0, 5'd0, 1'b0, 1'b1};
      else begin
        {e.exc, e.data} = unit_model(sel, op, frm, a, b, c);
        e.ill = 1'b0;
        e.to  = 1'b0;
      end
      exp_q.push_back(e);
      if (sel == 9 || sel == 10) mc_delay_q.push_back(dly);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < budget);
    if (!res_valid) check_output(tag, 32'(res_valid), 1);
  endtask

  task automatic wait_issue(input string tag, input logic [10:0] mask, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((fpu_valid_in & mask) == '0 && n < budget);
    if ((fpu_valid_in & mask) == '0) check_output(tag, 32'(fpu_valid_in & mask), 32'(mask));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) check_output(tag, 32'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic acc;
    int   base, n, sel, dly;

    rst_l = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_op = '0; cmd_frm = '0;
    cmd_a = '0; cmd_b = '0; cmd_c = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_cmd_ready", 32'(cmd_ready), 1);
    check_output("rst_fifo_count", 32'(fifo_count), 0);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_fpu_valid_in", 32'(fpu_valid_in), 0);
    check_output("rst_res_valid", 32'(res_valid), 0);
    check_output("rst_res_data", res_data, 0);
    rst_l = 1'b1;
    @(negedge clk);

    // single-cycle add: latency and one-cycle unit pulse
    base = vin_cnt[6];
    apply_stimulus(6, 2'd0, 3'd0, 32'h3F800000, 32'h40000000, 32'h0, 0, acc);
    @(negedge clk);
    check_output("add_count", 32'(fifo_count), 1);
    check_output("add_early_res", 32'(res_valid), 0);
    @(negedge clk);
    check_output("add_vin", 32'(fpu_valid_in), 32'h040);
    check_output("add_mid_res", 32'(res_valid), 0);
    @(negedge clk);
    check_output("add_res_valid", 32'(res_valid), 1);
    check_output("add_res_data", res_data, 32'h40400000);
    @(negedge clk);
    check_output("add_res_pulse", 32'(res_valid), 0);
    check_output("add_vin_pulses", 32'(vin_cnt[6] - base), 1);

    // done strobes while idle are ignored
    @(negedge clk); stray_div = 1'b1; stray_sqrt = 1'b1;
    @(negedge clk); stray_div = 1'b0; stray_sqrt = 1'b0;
    repeat (3) @(negedge clk);
    check_output("idle_stray_busy", 32'(busy), 0);

    // divide by zero through the multi-cycle path
    base = vin_cnt[9];
    apply_stimulus(9, 2'd0, 3'd0, 32'h3F800000, 32'h0, 32'h0, 27, acc);
    wait_result("div_wait", 100);
    check_output("div_data", res_data, 32'h7F800000);
    check_output("div_exc", 32'(res_exc), 32'h08);
    check_output("div_vin_pulses", 32'(vin_cnt[9] - base), 1);

    // illegal encodings, then a legal op=3 on minmax clears the flag
    base = total_vin();
    apply_stimulus(2, 2'd3, 3'd1, 32'h1234, 32'h5678, 32'h9, 0, acc);
    wait_result("ill1_wait", 20);
    check_output("ill1_flag", 32'(res_illegal), 1);
    apply_stimulus(12, 2'd0, 3'd0, 32'hAAAA, 32'hBBBB, 32'h1, 0, acc);
    wait_result("ill2_wait", 20);
    check_output("ill2_flag", 32'(res_illegal), 1);
    check_output("ill_no_vin", 32'(total_vin() - base), 0);
    apply_stimulus(3, 2'd3, 3'd2, 32'h11, 32'h22, 32'h33, 0, acc);
    wait_result("legal_wait", 20);
    check_output("legal_clears_ill", 32'(res_illegal), 0);

    // backpressure behind a stalled sqrt
    apply_stimulus(10, 2'd0, 3'd0, 32'h40800000, 32'h0, 32'h0, 40, acc);
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(7, 2'd0, 3'd0, 32'(i), 32'h3, 32'h0, 0, acc);
      check_output("bp_accept", 32'(acc), 1);
    end
    apply_stimulus(7, 2'd0, 3'd0, 32'd5, 32'h3, 32'h0, 0, acc);
    check_output("bp_reject", 32'(acc), 0);
    @(negedge clk);
    check_output("bp_count", 32'(fifo_count), 4);
    wait_drain("bp_drain", 200);

    // sqrt timeout with a stray divider done during the wait
    apply_stimulus(10, 2'd1, 3'd2, 32'h1, 32'h2, 32'h3, 0, acc);
    wait_issue("to_issue", 11'h400, 10);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      stray_div = (n == 20);
    end while (!res_valid && n < 100);
    stray_div = 1'b0;
    check_output("to_latency", 32'(n), 65);
    check_output("to_flag", 32'(res_timeout), 1);
    check_output("to_data", res_data, 0);

    // done on the last wait cycle wins; one cycle later is too late
    apply_stimulus(9, 2'd0, 3'd3, 32'h40400000, 32'h40000000, 32'h0, 64, acc);
    wait_result("edge64_wait", 100);
    check_output("edge64_timeout", 32'(res_timeout), 0);
    apply_stimulus(9, 2'd0, 3'd3, 32'h40400000, 32'h40000000, 32'h0, 65, acc);
    wait_result("edge65_wait", 100);
    check_output("edge65_timeout", 32'(res_timeout), 1);
    wait_drain("edge_drain", 20);

    // randomized burst, never pushing beyond what the FIFO can hold
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (exp_q.size() >= DEPTH && n < 1000) begin
        @(negedge clk);
        n++;
      end
      sel = $urandom_range(0, 12);
      dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 70);
      apply_stimulus(sel, 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, dly, acc);
      check_output("rand_accept", 32'(acc), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain("rand_drain", 3000);

    // flush while a divide waits with two commands queued
    apply_stimulus(9, 2'd0, 3'd0, 32'h5, 32'h7, 32'h0, 50, acc);
    wait_issue("fl_issue", 11'h200, 10);
    apply_stimulus(6, 2'd1, 3'd0, 32'h8, 32'h9, 32'h0, 0, acc);
    apply_stimulus(7, 2'd0, 3'd0, 32'hA, 32'hB, 32'h0, 0, acc);
    base = res_seen;
    @(negedge clk);
    flush = 1'b1;
    cmd_valid = 1'b1; cmd_sel = 4'd6;
    #1;
    check_output("fl_cancel", 32'(fpu_cancel), 1);
    check_output("fl_ready", 32'(cmd_ready), 0);
    @(posedge clk);
    #1 flush = 1'b0; cmd_valid = 1'b0;
    exp_q.delete();
    mc_delay_q.delete();
    @(negedge clk);
    check_output("fl_count", 32'(fifo_count), 0);
    check_output("fl_busy", 32'(busy), 0);
    check_output("fl_cancel_pulse", 32'(fpu_cancel), 0);
    repeat (80) @(negedge clk);
    check_output("fl_no_result", 32'(res_seen - base), 0);

    // asynchronous reset while a command is in ISSUE
    apply_stimulus(6, 2'd0, 3'd0, 32'h3F800000, 32'h40000000, 32'h0, 0, acc);
    wait_result("pre_rst_wait", 20);
    apply_stimulus(7, 2'd2, 3'd1, 32'hDEAD, 32'hBEEF, 32'h1, 0, acc);
    wait_issue("rst_issue", 11'h080, 10);
    #1 rst_l = 1'b0;
    #1;
    check_output("arst_vin", 32'(fpu_valid_in), 0);
    check_output("arst_fpu_a", fpu_a, 0);
    check_output("arst_res_data", res_data, 0);
    check_output("arst_busy", 32'(busy), 0);
    check_output("arst_count", 32'(fifo_count), 0);
    check_output("arst_cancel", 32'(fpu_cancel), 0);
    exp_q.delete();
    mc_delay_q.delete();
    base = res_seen;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    repeat (5) @(negedge clk);
    check_output("arst_no_result", 32'(res_seen - base), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
